phased_row_decoder: RTL and testbench
=====================================

# phased_row_decoder

Parametrised, registered row-enable decoder for the phased cache. It converts a set index into a one-hot tag-array row enable. One cycle later it samples the tag-compare result. It then issues the one-hot data-array row enable only on a hit, so the data array is never read on a miss. It sits between the cache controller's request port and the tag/data SRAM row selects.

## Interface
Parameters:
- IDX_W, 4, set-index width; OUT_W = 2**IDX_W is derived and not overridable.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_idx  in  IDX_W  set index.
- req_en  in  1  decode enable; 0 means accept the request and issue no row enables.
- tag_rd_en  out  OUT_W  one-hot tag-array row enable, registered.
- tag_hit  in  1  tag-compare result, valid in the CMP state.
- data_rd_en  out  OUT_W  one-hot data-array row enable, registered.
- done_valid  out  1  one-cycle completion pulse.
- done_hit  out  1  hit flag, qualified by done_valid.

## Operation
- FSM states: IDLE, TAG, CMP, DATA.
- req_ready = 1 only in IDLE.
- Acceptance occurs when req_valid & req_ready are both high at a clock edge. The block latches req_idx and req_en.
- Transitions out of IDLE:
  - IDLE→TAG on acceptance with req_en=1.
  - On acceptance with req_en=0, the block stays in IDLE and pulses done_valid=1, done_hit=0 next cycle. No enables are issued.
- TAG: tag_rd_en = one-hot(idx); all other bits are 0. TAG→CMP unconditionally.
- CMP: tag_rd_en = 0 and tag_hit is sampled.
  - tag_hit=1: CMP→DATA.
  - tag_hit=0: CMP→IDLE, with done_valid=1, done_hit=0 in the following cycle.
- DATA: data_rd_en = one-hot(idx). DATA→IDLE, with done_valid=1, done_hit=1 in the following cycle.
- tag_rd_en and data_rd_en never have more than one bit set. Both are zero in IDLE.
- A completion cycle is also an IDLE cycle, so a new request can be accepted in the same cycle done_valid is high.
- tag_hit is ignored outside CMP.
- req_idx and req_en are ignored except at acceptance.
- Every IDX_W-bit index is legal; there is no out-of-range case.

## Timing
- Reset values: state=IDLE, req_ready=1, tag_rd_en=0, data_rd_en=0, done_valid=0, done_hit=0, latched idx/en=0.
- Reset asserted mid-operation aborts the request with no done pulse. All outputs go to their reset values immediately (asynchronous).
- Cycle numbering: acceptance edge ends cycle A.
  - Hit: tag_rd_en high in A+1; tag_hit sampled in A+2; data_rd_en high in A+3; done_valid in A+4.
  - Miss: done_valid in A+3.
  - req_en=0: done_valid in A+1.
- Throughput: one request per 4 cycles on a hit, one per 3 on a miss, back-to-back with no bubble after done.

## Configuration
- Macro: PHASED_ROW_DECODER_PARALLEL_EN.
- Undefined (default, phased): behaviour as described above.
- Defined (parallel mode):
  - data_rd_en = one-hot(idx) is asserted in TAG together with tag_rd_en.
  - The DATA state is never entered.
  - CMP→IDLE for both hit and miss, with done_hit = sampled tag_hit.
  - done_valid occurs in A+3 for both outcomes.
  - Interface unchanged.

## Structure
- Package phased_cache_pkg holds:
  - the FSM state typedef (2-bit enum IDLE/TAG/CMP/DATA);
  - a localparam for the default IDX_W.
- Sub-module onehot_decoder: parametrised combinational IDX_W→2**IDX_W decoder with enable input; output all-zero when enable=0.
- Instantiate onehot_decoder once. Its output feeds both enable registers, gated by state.

## Test plan
- Reset, then IDX_W=4, accept idx=4'hA, en=1, tag_hit=1 in CMP:
  - tag_rd_en=16'h0400 in A+1 only;
  - data_rd_en=16'h0400 in A+3 only;
  - done_valid=1, done_hit=1 in A+4.
- idx=4'h3, tag_hit=0: tag_rd_en=16'h0008 in A+1, data_rd_en stays 0, done_valid=1 and done_hit=0 in A+3.
- req_en=0, idx=4'hF: no enables ever set, done_valid=1 and done_hit=0 in A+1, req_ready stays 1.
- Back-to-back hit then miss (idx 0 then 15), with req_valid held high:
  - second request accepted in the first request's done cycle;
  - tag_rd_en=16'h8000 four cycles after the first tag_rd_en.
- Assert rst_n=0 during DATA: data_rd_en drops to 0 asynchronously, no done pulse, req_ready=1 after release.
- With PHASED_ROW_DECODER_PARALLEL_EN defined, idx=4'h1, tag_hit=0: tag_rd_en and data_rd_en both 16'h0002 in A+1, done_valid=1 and done_hit=0 in A+3.

Source files
------------

// File: rtl/phased_cache_pkg.sv
// Shared types for the phased cache row decoder: FSM state encoding and default index width.
package phased_cache_pkg;

   localparam int IDX_W_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      TAG  = 2'd1,
      CMP  = 2'd2,
      DATA = 2'd3
   } state_e;

endpackage

// File: rtl/onehot_decoder.sv
// Combinational index to one-hot decoder; the output is all-zero while i_en is low.
module onehot_decoder #(
   parameter int IDX_W = 4
) (
   input  logic [IDX_W-1:0]      i_idx,
   input  logic                  i_en,
   output logic [(2**IDX_W)-1:0] o_onehot
);

   always_comb begin
      o_onehot = '0;
      if (i_en) o_onehot[i_idx] = 1'b1;
   end

endmodule

// File: rtl/phased_row_decoder.sv
// Registered tag/data row-enable decoder for the phased cache.
// Build option: PHASED_ROW_DECODER_PARALLEL_EN reads data rows alongside tag rows (no DATA phase).
//
// state | meaning
// IDLE  | ready for a request; completion pulse cycle
// TAG   | tag-array row enable asserted
// CMP   | tag_hit sampled
// DATA  | data-array row enable asserted (hit only, phased build)
module phased_row_decoder
   import phased_cache_pkg::*;
#(
   parameter int IDX_W = IDX_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [IDX_W-1:0]      req_idx,
   input  logic                  req_en,
   output logic [(2**IDX_W)-1:0] tag_rd_en,
   input  logic                  tag_hit,
   output logic [(2**IDX_W)-1:0] data_rd_en,
   output logic                  done_valid,
   output logic                  done_hit
);

   localparam int OUT_W = 2**IDX_W;

   state_e             r_state;
   logic [IDX_W-1:0]   r_idx;
   logic               r_en;
   logic [OUT_W-1:0]   r_tag_rd_en;
   logic [OUT_W-1:0]   r_data_rd_en;
   logic               r_done_valid;
   logic               r_done_hit;

   logic [IDX_W-1:0]   w_dec_idx;
   logic               w_dec_en;
   logic [OUT_W-1:0]   w_dec;

   // In IDLE the live request is decoded so the tag enable lands in the cycle after acceptance;
   // later phases re-decode the latched index.
   assign w_dec_idx = (r_state == IDLE) ? req_idx : r_idx;
   assign w_dec_en  = (r_state == IDLE) ? req_en  : r_en;

   onehot_decoder #(.IDX_W(IDX_W)) u_dec (
      .i_idx    (w_dec_idx),
      .i_en     (w_dec_en),
      .o_onehot (w_dec)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_idx        <= '0;
         r_en         <= 1'b0;
         r_tag_rd_en  <= '0;
         r_data_rd_en <= '0;
         r_done_valid <= 1'b0;
         r_done_hit   <= 1'b0;
      end else begin
         r_tag_rd_en  <= '0;
         r_data_rd_en <= '0;
         r_done_valid <= 1'b0;
         r_done_hit   <= 1'b0;
         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_idx <= req_idx;
                  r_en  <= req_en;
                  if (req_en) begin
                     r_state     <= TAG;
                     r_tag_rd_en <= w_dec;
`ifdef PHASED_ROW_DECODER_PARALLEL_EN
                     r_data_rd_en <= w_dec;
`endif
                  end else begin
                     r_done_valid <= 1'b1;
                  end
               end
            end
            TAG: r_state <= CMP;
            CMP: begin
`ifdef PHASED_ROW_DECODER_PARALLEL_EN
               r_state      <= IDLE;
               r_done_valid <= 1'b1;
               r_done_hit   <= tag_hit;
`else
               if (tag_hit) begin
                  r_state      <= DATA;
                  r_data_rd_en <= w_dec;
               end else begin
                  r_state      <= IDLE;
                  r_done_valid <= 1'b1;
               end
`endif
            end
            DATA: begin
               r_state      <= IDLE;
               r_done_valid <= 1'b1;
               r_done_hit   <= 1'b1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign req_ready  = (r_state == IDLE);
   assign tag_rd_en  = r_tag_rd_en;
   assign data_rd_en = r_data_rd_en;
   assign done_valid = r_done_valid;
   assign done_hit   = r_done_hit;

endmodule

// File: tb/tb_phased_row_decoder.sv
// Directed bench for phased_row_decoder (phased build by default; parallel build via PHASED_ROW_DECODER_PARALLEL_EN).
module tb_phased_row_decoder;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_idx;
   logic        req_en;
   logic [15:0] tag_rd_en;
   logic        tag_hit;
   logic [15:0] data_rd_en;
   logic        done_valid;
   logic        done_hit;

   int checks   = 0;
   int failures = 0;

   phased_row_decoder #(.IDX_W(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_idx    (req_idx),
      .req_en     (req_en),
      .tag_rd_en  (tag_rd_en),
      .tag_hit    (tag_hit),
      .data_rd_en (data_rd_en),
      .done_valid (done_valid),
      .done_hit   (done_hit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_valid = 1'b0; req_idx = '0; req_en = 1'b0; tag_hit = 1'b0;
      tick(); tick();
      checks++; if (tag_rd_en !== 16'h0)  begin failures++; $display("FAIL reset_tag got=%h exp=0000", tag_rd_en); end
      checks++; if (data_rd_en !== 16'h0) begin failures++; $display("FAIL reset_data got=%h exp=0000", data_rd_en); end
      checks++; if (done_valid !== 1'b0)  begin failures++; $display("FAIL reset_done_valid got=%b exp=0", done_valid); end
      checks++; if (done_hit !== 1'b0)    begin failures++; $display("FAIL reset_done_hit got=%b exp=0", done_hit); end
      checks++; if (req_ready !== 1'b1)   begin failures++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
      rst_n = 1'b1;
      tick();
      checks++; if (req_ready !== 1'b1 || done_valid !== 1'b0) begin failures++; $display("FAIL post_reset_idle ready=%b done=%b exp=1/0", req_ready, done_valid); end
   endtask

   task automatic test_hit();
      req_valid = 1'b1; req_idx = 4'hA; req_en = 1'b1; tag_hit = 1'b0;
      tick();  // A+1
      req_valid = 1'b0; req_idx = 4'h0; tag_hit = 1'b1;
      checks++; if (tag_rd_en !== 16'h0400)  begin failures++; $display("FAIL hit_tag_a1 got=%h exp=0400", tag_rd_en); end
      checks++; if (data_rd_en !== 16'h0000) begin failures++; $display("FAIL hit_data_a1 got=%h exp=0000", data_rd_en); end
      checks++; if (req_ready !== 1'b0)      begin failures++; $display("FAIL hit_ready_a1 got=%b exp=0", req_ready); end
      tick();  // A+2
      checks++; if (tag_rd_en !== 16'h0 || data_rd_en !== 16'h0) begin failures++; $display("FAIL hit_a2 tag=%h data=%h exp=0000/0000", tag_rd_en, data_rd_en); end
      tick();  // A+3
      tag_hit = 1'b0;
      checks++; if (data_rd_en !== 16'h0400) begin failures++; $display("FAIL hit_data_a3 got=%h exp=0400", data_rd_en); end
      checks++; if (tag_rd_en !== 16'h0 || done_valid !== 1'b0) begin failures++; $display("FAIL hit_a3 tag=%h done=%b exp=0000/0", tag_rd_en, done_valid); end
      tick();  // A+4
      checks++; if (done_valid !== 1'b1 || done_hit !== 1'b1) begin failures++; $display("FAIL hit_done_a4 valid=%b hit=%b exp=1/1", done_valid, done_hit); end
      checks++; if (data_rd_en !== 16'h0 || req_ready !== 1'b1) begin failures++; $display("FAIL hit_a4 data=%h ready=%b exp=0000/1", data_rd_en, req_ready); end
      tick();  // A+5
      checks++; if (done_valid !== 1'b0) begin failures++; $display("FAIL hit_done_pulse got=%b exp=0", done_valid); end
   endtask

   task automatic test_miss();
      logic [15:0] data_seen;
      data_seen = '0;
      req_valid = 1'b1; req_idx = 4'h3; req_en = 1'b1; tag_hit = 1'b0;
      tick();  // A+1
      req_valid = 1'b0; data_seen |= data_rd_en;
      checks++; if (tag_rd_en !== 16'h0008) begin failures++; $display("FAIL miss_tag_a1 got=%h exp=0008", tag_rd_en); end
      tick();  // A+2
      data_seen |= data_rd_en;
      checks++; if (done_valid !== 1'b0) begin failures++; $display("FAIL miss_early_done got=%b exp=0", done_valid); end
      tick();  // A+3
      data_seen |= data_rd_en;
      checks++; if (done_valid !== 1'b1 || done_hit !== 1'b0) begin failures++; $display("FAIL miss_done_a3 valid=%b hit=%b exp=1/0", done_valid, done_hit); end
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL miss_ready_a3 got=%b exp=1", req_ready); end
      tick();  // A+4
      data_seen |= data_rd_en;
      checks++; if (data_seen !== 16'h0) begin failures++; $display("FAIL miss_data_never got=%h exp=0000", data_seen); end
      checks++; if (done_valid !== 1'b0) begin failures++; $display("FAIL miss_done_pulse got=%b exp=0", done_valid); end
   endtask

   task automatic test_no_en();
      req_valid = 1'b1; req_idx = 4'hF; req_en = 1'b0; tag_hit = 1'b1;
      tick();  // A+1
      req_valid = 1'b0; req_en = 1'b1; tag_hit = 1'b0;
      checks++; if (done_valid !== 1'b1 || done_hit !== 1'b0) begin failures++; $display("FAIL noen_done_a1 valid=%b hit=%b exp=1/0", done_valid, done_hit); end
      checks++; if (tag_rd_en !== 16'h0 || data_rd_en !== 16'h0) begin failures++; $display("FAIL noen_enables tag=%h data=%h exp=0000/0000", tag_rd_en, data_rd_en); end
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL noen_ready got=%b exp=1", req_ready); end
      tick();  // A+2
      checks++; if (done_valid !== 1'b0 || tag_rd_en !== 16'h0) begin failures++; $display("FAIL noen_a2 done=%b tag=%h exp=0/0000", done_valid, tag_rd_en); end
   endtask

   task automatic test_back_to_back();
      req_valid = 1'b1; req_idx = 4'h0; req_en = 1'b1; tag_hit = 1'b0;
      tick();  // A+1
      req_idx = 4'hF; tag_hit = 1'b1;
      checks++; if (tag_rd_en !== 16'h0001) begin failures++; $display("FAIL b2b_tag1 got=%h exp=0001", tag_rd_en); end
      tick();  // A+2
      tick();  // A+3
      tag_hit = 1'b0;
      checks++; if (data_rd_en !== 16'h0001) begin failures++; $display("FAIL b2b_data1 got=%h exp=0001", data_rd_en); end
      tick();  // A+4: first done, second accepted at the end of this cycle
      checks++; if (done_valid !== 1'b1 || done_hit !== 1'b1 || req_ready !== 1'b1) begin failures++; $display("FAIL b2b_done1 valid=%b hit=%b ready=%b exp=1/1/1", done_valid, done_hit, req_ready); end
      tick();  // A+5
      req_valid = 1'b0;
      checks++; if (tag_rd_en !== 16'h8000) begin failures++; $display("FAIL b2b_tag2 got=%h exp=8000", tag_rd_en); end
      checks++; if (req_ready !== 1'b0 || done_valid !== 1'b0) begin failures++; $display("FAIL b2b_a5 ready=%b done=%b exp=0/0", req_ready, done_valid); end
      tick();  // A+6
      tick();  // A+7
      checks++; if (done_valid !== 1'b1 || done_hit !== 1'b0) begin failures++; $display("FAIL b2b_done2 valid=%b hit=%b exp=1/0", done_valid, done_hit); end
      checks++; if (data_rd_en !== 16'h0) begin failures++; $display("FAIL b2b_data2 got=%h exp=0000", data_rd_en); end
      tick();
   endtask

   task automatic test_reset_mid();
      req_valid = 1'b1; req_idx = 4'h5; req_en = 1'b1; tag_hit = 1'b1;
      tick();  // A+1
      req_valid = 1'b0;
      tick();  // A+2
      tick();  // A+3
      tag_hit = 1'b0;
      checks++; if (data_rd_en !== 16'h0020) begin failures++; $display("FAIL rst_data_before got=%h exp=0020", data_rd_en); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (data_rd_en !== 16'h0) begin failures++; $display("FAIL rst_async_data got=%h exp=0000", data_rd_en); end
      checks++; if (req_ready !== 1'b1 || done_valid !== 1'b0) begin failures++; $display("FAIL rst_async_state ready=%b done=%b exp=1/0", req_ready, done_valid); end
      tick();
      rst_n = 1'b1;
      tick();
      checks++; if (done_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL rst_release done=%b ready=%b exp=0/1", done_valid, req_ready); end
      tick();
      checks++; if (done_valid !== 1'b0 || data_rd_en !== 16'h0) begin failures++; $display("FAIL rst_no_done done=%b data=%h exp=0/0000", done_valid, data_rd_en); end
   endtask

   task automatic test_parallel();
      req_valid = 1'b1; req_idx = 4'h1; req_en = 1'b1; tag_hit = 1'b0;
      tick();  // A+1
      req_valid = 1'b0;
      checks++; if (tag_rd_en !== 16'h0002 || data_rd_en !== 16'h0002) begin failures++; $display("FAIL par_a1 tag=%h data=%h exp=0002/0002", tag_rd_en, data_rd_en); end
      tick();  // A+2
      checks++; if (data_rd_en !== 16'h0) begin failures++; $display("FAIL par_a2_data got=%h exp=0000", data_rd_en); end
      tick();  // A+3
      checks++; if (done_valid !== 1'b1 || done_hit !== 1'b0) begin failures++; $display("FAIL par_miss_done valid=%b hit=%b exp=1/0", done_valid, done_hit); end
      req_valid = 1'b1; req_idx = 4'h6; tag_hit = 1'b1;
      tick();  // A+1
      req_valid = 1'b0;
      checks++; if (tag_rd_en !== 16'h0040 || data_rd_en !== 16'h0040) begin failures++; $display("FAIL par_hit_a1 tag=%h data=%h exp=0040/0040", tag_rd_en, data_rd_en); end
      tick();
      tick();  // A+3
      checks++; if (done_valid !== 1'b1 || done_hit !== 1'b1) begin failures++; $display("FAIL par_hit_done valid=%b hit=%b exp=1/1", done_valid, done_hit); end
      tick();
   endtask

   initial begin
      test_reset();
`ifdef PHASED_ROW_DECODER_PARALLEL_EN
      test_no_en();
      test_parallel();
`else
      test_hit();
      test_miss();
      test_no_en();
      test_back_to_back();
      test_reset_mid();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
